combo_scanner: RTL and testbench
================================

Name: combo_scanner

Overview:
- Upstream stage for the 5-input condition checker (inputs A..E, one combinational validity output).
- On a start command, walks all 2^N candidate input combinations and drives each onto the checker inputs. It samples the checker's verdict in the same cycle.
- Each combination the checker flags valid is emitted on a ready/valid output stream. The block keeps a running count of valid combinations and pulses done when the sweep completes.

Parameters:
- N, 5, number of condition bits (candidate width); bit N-1 maps to A, bit 0 maps to E.
- CNT_W, 6, width of valid_count; must be at least N+1 so a full count of 2^N fits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE, ignored otherwise
- cand  out  N  candidate combination driven to the checker (A=cand[N-1] .. E=cand[0])
- chk_valid  in  1  checker verdict for the current cand; combinational, same cycle
- out_valid  out  1  out_data holds a valid combination
- out_ready  in  1  downstream accepts out_data when out_valid&&out_ready
- out_data  out  N  registered copy of the valid combination
- busy  out  1  high in SCAN/HOLD
- done  out  1  one-cycle pulse at sweep end
- valid_count  out  CNT_W  number of valid combinations accepted in the current/last sweep

Behaviour:
- Reset values (synchronous): state=IDLE, idx=0, cand=0, out_valid=0, out_data=0, busy=0, done=0, valid_count=0. Reset wins over every other event, including mid-sweep and while out_valid is high; no partial output survives.
- cand is driven combinationally from the idx register in every state. In IDLE and DONE, idx=0.
- IDLE:
  - start=1 moves to SCAN, with idx=0 and valid_count cleared to 0 on the same edge.
  - valid_count otherwise holds its last-sweep value.
- SCAN, one candidate per cycle:
  - chk_valid=1: register out_data<=idx and out_valid<=1, then go to HOLD.
  - chk_valid=0 and idx==2^N-1: go to DONE.
  - chk_valid=0 and idx<2^N-1: idx<=idx+1.
- HOLD:
  - out_valid, out_data and cand stay stable until out_valid&&out_ready.
  - On acceptance: out_valid<=0 and valid_count<=valid_count+1. Then idx==2^N-1 goes to DONE; otherwise idx<=idx+1 and return to SCAN.
  - out_ready low stalls indefinitely with no data loss.
  - out_ready may be high before out_valid; acceptance needs both high on the same edge.
- DONE:
  - done=1 for exactly one cycle, then IDLE. busy=0.
  - A start during DONE is ignored.
- Latency:
  - Invalid candidate: 1 cycle.
  - Valid candidate: 1 SCAN cycle plus at least 1 HOLD cycle.
  - Full sweep with out_ready tied high: 2^N + V edges from the start-sampling edge to DONE, where V is the number of valid combinations.
- Wrap-around: idx never wraps. The terminal check at idx==2^N-1 ends the sweep, including when the last candidate is valid (HOLD goes to DONE).
- Widths: idx is N bits. valid_count is zero-extended arithmetic and cannot overflow, since CNT_W≥N+1.
- The outputs busy and done are registered/state-decoded with no glitch paths from inputs. cand depends only on idx.

Decomposition:
- Shared package: N default, state encoding localparams (IDLE, SCAN, HOLD, DONE), and the terminal index constant 2^N-1.
- No sub-module inside combo_scanner. The checker is instantiated alongside it at the parent level, cand→A..E and its valid output→chk_valid.
- The bench instantiates the gate-level checker equations as the reference model.

Test Plan:
- Reset, then start pulse, out_ready=1, checker wired in:
  - Expect exactly one transfer, out_data=5'b10100, during which cand=5'b10100.
  - valid_count=1, done high one cycle, 33 edges after the start-sampling edge.
- Same sweep with out_ready held low for 5 cycles during HOLD:
  - out_data and cand stable throughout; done at 38 edges; valid_count=1.
- Stubbed checker with chk_valid=1 always, out_ready=1:
  - 32 transfers in order 0..31; valid_count=32; last candidate valid goes to DONE with no wrap.
- Stubbed checker with chk_valid=0 always:
  - No out_valid ever; done after 32 edges; valid_count=0; previous count cleared on start.
- rst asserted in HOLD with out_valid=1:
  - Next cycle all outputs at reset values.
  - A start during busy/DONE is ignored (no restart, idx unaffected).
- Back-to-back sweeps: start in the cycle after done returns to IDLE → second sweep identical; valid_count cleared then ends at 1.

Source files
------------

// File: rtl/combo_scanner_pkg.sv
// Shared definitions for the combination scanner: default widths, FSM
// state encoding and the terminal-index helper.
package combo_scanner_pkg;

    // Default number of condition bits (A..E).
    localparam int N_DEF = 5;

    // Default valid-count width; N_DEF+1 bits hold a full count of 2^N_DEF.
    localparam int CNT_W_DEF = 6;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Last candidate index for an n-bit sweep (2^n - 1).
    function automatic logic [31:0] term_index(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    // Terminal index for the default width.
    localparam logic [N_DEF-1:0] TERM_IDX = {N_DEF{1'b1}};

endpackage

// File: rtl/combo_scanner_if.sv
// Ready/valid output stream carrying each combination the checker accepts.
interface combo_scanner_if
    import combo_scanner_pkg::*;
#(
    parameter int N = N_DEF
) ();

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    // Producer side (the scanner).
    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    // Consumer side (downstream logic).
    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/combo_scanner.sv
// Walks every N-bit candidate, presents it to an external combinational
// condition checker, and streams out each candidate the checker accepts.
// A valid candidate is parked in HOLD until the consumer takes it, so a
// stalled consumer never loses data. The sweep ends on the terminal index
// (the index never wraps) and raises a one-cycle done pulse.
module combo_scanner
    import combo_scanner_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic [N-1:0]      cand_o,
    input  logic              chk_valid_i,
    combo_scanner_if.master   out_if,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  valid_count_o
);

    // Highest candidate index; reaching it ends the sweep.
    localparam logic [N-1:0] LAST_IDX = N'(term_index(N));

    state_e             state_q;
    logic [N-1:0]       idx_q;
    logic [N-1:0]       out_data_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   valid_count_q;

    logic [N-1:0]       idx_next_d;
    logic [CNT_W-1:0]   count_next_d;
    logic               idx_last_s;
    logic               accept_s;

    // Index/count increments and terminal / handshake decodes.
    always_comb begin
        idx_next_d   = idx_q + N'(1);
        count_next_d = valid_count_q + CNT_W'(1);
        idx_last_s   = (idx_q == LAST_IDX);
        accept_s     = out_valid_q && out_if.out_ready;
    end

    // Sweep controller: state, candidate index, output register, count and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= {N{1'b0}};
            out_data_q    <= {N{1'b0}};
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            valid_count_q <= {CNT_W{1'b0}};
        end else begin
            // done is a single-cycle pulse; only the DONE entry raises it.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    idx_q <= {N{1'b0}};
                    if (start_i) begin
                        state_q       <= ST_SCAN;
                        busy_q        <= 1'b1;
                        valid_count_q <= {CNT_W{1'b0}};
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                ST_SCAN: begin
                    if (chk_valid_i) begin
                        // Capture the accepted candidate; idx stays put so
                        // cand remains stable for the whole HOLD.
                        out_data_q  <= idx_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else if (idx_last_s) begin
                        state_q <= ST_DONE;
                        idx_q   <= {N{1'b0}};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_next_d;
                    end
                end

                ST_HOLD: begin
                    if (accept_s) begin
                        out_valid_q   <= 1'b0;
                        valid_count_q <= count_next_d;
                        if (idx_last_s) begin
                            state_q <= ST_DONE;
                            idx_q   <= {N{1'b0}};
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SCAN;
                            idx_q   <= idx_next_d;
                        end
                    end else begin
                        // Stalled consumer: hold everything.
                        state_q <= ST_HOLD;
                    end
                end

                ST_DONE: begin
                    // Start is deliberately not examined here.
                    state_q <= ST_IDLE;
                    idx_q   <= {N{1'b0}};
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    idx_q       <= {N{1'b0}};
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Candidate depends only on the index register; outputs come straight from flops.
    always_comb begin
        cand_o           = idx_q;
        out_if.out_valid = out_valid_q;
        out_if.out_data  = out_data_q;
        busy_o           = busy_q;
        done_o           = done_q;
        valid_count_o    = valid_count_q;
    end

endmodule

// File: tb/tb_combo_scanner.sv
// Scoreboard bench for combo_scanner with the gate-level checker as reference.
module tb_combo_scanner;

    localparam int N     = 5;
    localparam int CNT_W = 6;

    logic             clk;
    logic             rst;
    logic             start_i;
    logic [N-1:0]     cand;
    logic             chk_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] valid_count;

    combo_scanner_if #(.N(N)) sif ();

    combo_scanner #(.N(N), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .cand_o        (cand),
        .chk_valid_i   (chk_valid),
        .out_if        (sif),
        .busy_o        (busy),
        .done_o        (done),
        .valid_count_o (valid_count)
    );

    // Reference checker gates: valid only for A=1,B=0,C=1,D=0,E=0.
    logic a_s, b_s, c_s, d_s, e_s, ref_valid;
    assign a_s = cand[4];
    assign b_s = cand[3];
    assign c_s = cand[2];
    assign d_s = cand[1];
    assign e_s = cand[0];
    assign ref_valid = a_s & ~b_s & c_s & ~d_s & ~e_s;

    // mode 0: reference checker, 1: always valid, 2: never valid
    int mode;
    assign chk_valid = (mode == 1) ? 1'b1 : ((mode == 2) ? 1'b0 : ref_valid);

    int checks;
    int errors;
    int stall_left;
    logic [N-1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Consumer: holds ready low while stall cycles remain, high otherwise.
    initial begin
        sif.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (sif.out_valid && stall_left > 0) begin
                sif.out_ready = 1'b0;
                stall_left--;
            end else begin
                sif.out_ready = 1'b1;
            end
        end
    end

    // Monitor: checks hold stability and pops the scoreboard on each transfer.
    initial begin
        logic [N-1:0] hold_data;
        logic [N-1:0] exp;
        bit have_hold;
        have_hold = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst || !sif.out_valid) begin
                have_hold = 1'b0;
            end else begin
                chk("cand_eq_out_data", int'(cand), int'(sif.out_data));
                if (have_hold) begin
                    chk("hold_data_stable", int'(sif.out_data), int'(hold_data));
                end else begin
                    hold_data = sif.out_data;
                    have_hold = 1'b1;
                end
                if (sif.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_transfer actual=%0d expected=none", sif.out_data);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("out_data", int'(sif.out_data), int'(exp));
                    end
                    have_hold = 1'b0;
                end
            end
        end
    end

    // One sweep: start, count edges to done, check count, pulse width and idle.
    task automatic run_sweep(input string tag, input int exp_edges, input int exp_cnt,
                             input bit poke_mid, input bit poke_done);
        int edges;
        bit seen;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk({tag, "_busy_at_start"}, int'(busy), 1);
        chk({tag, "_count_cleared"}, int'(valid_count), 0);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 300) begin
            start_i = (poke_mid && edges == 10) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            edges++;
            if (done) seen = 1'b1;
        end
        start_i = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done expected=done_by_%0d", tag, exp_edges);
        end
        chk({tag, "_done_edges"}, edges, exp_edges);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        chk({tag, "_valid_count"}, int'(valid_count), exp_cnt);
        chk({tag, "_scoreboard_empty"}, exp_q.size(), 0);
        if (poke_done) start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_idle_not_busy"}, int'(busy), 0);
        if (poke_done) begin
            @(posedge clk);
            #1;
            chk({tag, "_start_in_done_ignored"}, int'(busy), 0);
        end
    endtask

    initial begin
        int w;
        checks     = 0;
        errors     = 0;
        stall_left = 0;
        mode       = 0;
        rst        = 1'b1;
        start_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cand", int'(cand), 0);
        chk("rst_out_valid", int'(sif.out_valid), 0);
        chk("rst_out_data", int'(sif.out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid_count", int'(valid_count), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reference checker, consumer always ready.
        mode = 0;
        exp_q.push_back(5'b10100);
        run_sweep("ref", 33, 1, 1'b0, 1'b0);

        // Reference checker, consumer stalls five cycles in HOLD.
        stall_left = 5;
        exp_q.push_back(5'b10100);
        run_sweep("stall", 38, 1, 1'b0, 1'b0);

        // Every candidate valid: 0..31 in order, last one ends via HOLD.
        mode = 1;
        for (int i = 0; i < 32; i++) exp_q.push_back(5'(i));
        run_sweep("all", 64, 32, 1'b0, 1'b0);

        // No candidate valid; also pokes start mid-sweep and during DONE.
        mode = 2;
        run_sweep("none", 32, 0, 1'b1, 1'b1);

        // Back-to-back sweeps, second started the cycle after DONE.
        mode = 0;
        exp_q.push_back(5'b10100);
        run_sweep("b2b1", 33, 1, 1'b0, 1'b0);
        exp_q.push_back(5'b10100);
        run_sweep("b2b2", 33, 1, 1'b0, 1'b0);

        // Reset while parked in HOLD with out_valid high.
        stall_left = 1000;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        w = 0;
        while (!sif.out_valid && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("hold_reached", int'(sif.out_valid), 1);
        chk("hold_cand", int'(cand), 20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall_left = 0;
        chk("midrst_cand", int'(cand), 0);
        chk("midrst_out_valid", int'(sif.out_valid), 0);
        chk("midrst_out_data", int'(sif.out_data), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_valid_count", int'(valid_count), 0);
        @(posedge clk);
        #1;
        chk("midrst_stays_idle", int'(busy), 0);

        // Recovery sweep after the reset.
        exp_q.push_back(5'b10100);
        run_sweep("recover", 33, 1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
